// File: rtl/mem_access_ctrl_if.sv
// Request/response/RAM bus bundle for mem_access_ctrl.
// slave  : the controller side (accepts CPU requests, drives the RAM port).
// master : the CPU datapath plus the RAM wrapper seen from outside.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, ram_dout,
        output req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, ram_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator for a synchronous
// single-port RAM. All outputs come straight from registers.
// Optional feature macro: MEM_READBACK_VERIFY_EN (stores are read back and
// compared; mismatch flags resp_err).
module mem_access_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_RESP   = 3'd3;
`ifdef MEM_READBACK_VERIFY_EN
    localparam logic [2:0] ST_VERIFY = 3'd4;
`endif
    localparam logic [2:0] LAT       = 3'(RAM_LATENCY);

    logic [2:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  ram_we_q, ram_we_d;
    logic [15:0]           ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    logic                  addr_oob_s;

    // Any address bit above the implemented RAM range marks the request as an error.
    assign addr_oob_s = ((bus.req_addr >> ADDR_WIDTH) != 16'd0);

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        err_d        = err_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    we_d        = bus.req_we;
                    err_d       = addr_oob_s;
                    state_d     = ST_ISSUE;
                    if (addr_oob_s) begin
                        // Out-of-range: RAM port left untouched, one dead cycle
                        // keeps the error latency equal to a store's.
                        ram_we_d = 1'b0;
                    end else begin
                        ram_addr_d = bus.req_addr;
                        ram_din_d  = bus.req_wdata;
                        ram_we_d   = bus.req_we;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                ram_we_d = 1'b0;
                if (err_q) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = {DATA_WIDTH{1'b0}};
                end else if (we_q) begin
`ifdef MEM_READBACK_VERIFY_EN
                    state_d = ST_VERIFY;
`else
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = {DATA_WIDTH{1'b0}};
`endif
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT;
                end
            end
`ifdef MEM_READBACK_VERIFY_EN
            ST_VERIFY: begin
                // Read the just-written word back from the same address.
                ram_we_d = 1'b0;
                state_d  = ST_WAIT;
                cnt_d    = LAT;
            end
`endif
            ST_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    cnt_d        = 3'd0;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = bus.ram_dout;
`ifdef MEM_READBACK_VERIFY_EN
                    resp_err_d   = we_q && (bus.ram_dout != ram_din_q);
`else
                    resp_err_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a quiet idle.
                state_d      = ST_IDLE;
                cnt_d        = 3'd0;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                ram_we_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= {DATA_WIDTH{1'b0}};
            ram_we_q     <= 1'b0;
            ram_addr_q   <= 16'd0;
            ram_din_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_din    = ram_din_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, hand-written
// reset/stall sequences, then random traffic against a word-array reference.
module tb_mem_access_ctrl;
`ifdef MEM_READBACK_VERIFY_EN
    localparam bit VER = 1'b1;
    localparam int LAT = 3;
`else
    localparam bit VER = 1'b0;
    localparam int LAT = 1;
`endif
    localparam int STL = VER ? (2 + LAT) : 1;
    localparam int LDL = 1 + LAT;

    logic clk;
    logic rst_n;
    logic corrupt;
    mem_access_ctrl_if bus();

    mem_access_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .RAM_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM wrapper model: read-first, LAT-stage output pipeline.
    logic [15:0] ram_mem [256];
    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr[7:0]] <= bus.ram_din;
        pipe[0] <= ram_mem[bus.ram_addr[7:0]];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.ram_dout = pipe[LAT-1] ^ {15'd0, corrupt};

    // Reference model: expected word contents.
    logic [15:0] ref_mem [256];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          hold;
        bit          keep_valid;
    } vec_t;

    task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int hold, input bit keep_valid, input string tag);
        int lat;
        int wcnt;
        bit stable;
        logic [15:0] rd0;
        @(negedge clk);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        if (!keep_valid) bus.req_valid = 1'b0;
        lat  = 0;
        wcnt = 0;
        while (!bus.resp_valid && lat < 20) begin
            wcnt += int'(bus.ram_we);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
        chk({tag, "_err"}, bus.resp_err, exp_err);
        chk({tag, "_we_pulses"}, wcnt, (we && addr < 16'd256) ? 1 : 0);
        rd0    = bus.resp_rdata;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_rdata !== rd0 || bus.req_ready || bus.ram_we)
                stable = 1'b0;
        end
        if (hold > 0) chk({tag, "_stall_stable"}, stable, 1);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk({tag, "_resp_dropped"}, bus.resp_valid, 0);
        chk({tag, "_back_idle"}, bus.req_ready, 1);
    endtask

    vec_t tbl [6];

    initial begin
        logic [15:0] st_a5;
        logic [15:0] st_ff;
        bit          quiet;
        st_a5 = VER ? 16'hBEEF : 16'h0000;
        st_ff = VER ? 16'h1234 : 16'h0000;
        tbl[0] = '{1'b1, 16'h00A5, 16'hBEEF, st_a5,    1'b0, STL, 0,  1'b0};
        tbl[1] = '{1'b0, 16'h00A5, 16'h0000, 16'hBEEF, 1'b0, LDL, 0,  1'b0};
        tbl[2] = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1,   0,  1'b0};
        tbl[3] = '{1'b1, 16'h00FF, 16'h1234, st_ff,    1'b0, STL, 0,  1'b0};
        tbl[4] = '{1'b0, 16'h00FF, 16'h0000, 16'h1234, 1'b0, LDL, 10, 1'b1};
        tbl[5] = '{1'b1, 16'hFFFF, 16'h7777, 16'h0000, 1'b1, 1,   2,  1'b0};

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 16'd0;
            ref_mem[i] = 16'd0;
        end
        for (int k = 0; k < LAT; k++) pipe[k] = 16'd0;
        corrupt        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 16'd0;
        bus.req_wdata  = 16'd0;
        bus.resp_ready = 1'b0;
        rst_n          = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_outputs", {bus.ram_we, bus.resp_err, bus.ram_addr, bus.ram_din, bus.resp_rdata}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", bus.req_ready, 1);
        chk("post_rst_ram_we", bus.ram_we, 0);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err,
                   tbl[i].exp_lat, tbl[i].hold, tbl[i].keep_valid, $sformatf("vec%0d", i));
            if (tbl[i].we && tbl[i].addr < 16'd256) ref_mem[tbl[i].addr[7:0]] = tbl[i].wdata;
        end

        // Reset while a load is waiting on RAM data.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h00A5;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", bus.req_ready, 1);
        chk("midrst_outputs", {bus.resp_valid, bus.ram_we, bus.ram_addr, bus.resp_rdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) quiet = 1'b0;
        end
        chk("midrst_no_resp", quiet, 1);
        do_txn(1'b1, 16'h0010, 16'hC0DE, VER ? 16'hC0DE : 16'h0000, 1'b0, STL, 0, 1'b0, "post_rst_st");
        ref_mem[8'h10] = 16'hC0DE;
        do_txn(1'b0, 16'h0010, 16'h0000, 16'hC0DE, 1'b0, LDL, 0, 1'b0, "post_rst_ld");

`ifdef MEM_READBACK_VERIFY_EN
        // Read-back verification: clean store, then a store seen through a faulty RAM.
        do_txn(1'b1, 16'h0020, 16'h5A5A, 16'h5A5A, 1'b0, 5, 0, 1'b0, "verify_ok");
        ref_mem[8'h20] = 16'h5A5A;
        corrupt = 1'b1;
        do_txn(1'b1, 16'h0021, 16'h1111, 16'h1110, 1'b1, 5, 0, 1'b0, "verify_bad");
        ref_mem[8'h21] = 16'h1111;
        corrupt = 1'b0;
`endif

        // Random traffic against the reference array.
        for (int n = 0; n < 40; n++) begin
            logic        we;
            logic [15:0] addr;
            logic [15:0] wdata;
            logic [15:0] exp_rd;
            logic        oob;
            int          sel;
            int          lat;
            we    = 1'($urandom_range(0, 1));
            wdata = 16'($urandom);
            sel   = int'($urandom_range(0, 9));
            if (sel == 0)      addr = 16'h0100 + 16'($urandom_range(0, 16'hFEFF));
            else if (sel == 1) addr = 16'h00FF;
            else               addr = 16'($urandom_range(0, 15));
            oob = (addr >= 16'd256);
            if (oob) begin
                exp_rd = 16'd0;
                lat    = 1;
            end else if (we) begin
                exp_rd = VER ? wdata : 16'd0;
                lat    = STL;
            end else begin
                exp_rd = ref_mem[addr[7:0]];
                lat    = LDL;
            end
            do_txn(we, addr, wdata, exp_rd, oob, lat, int'($urandom_range(0, 3)), 1'b0,
                   $sformatf("rnd%0d", n));
            if (we && !oob) ref_mem[addr[7:0]] = wdata;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
